// File: rtl/proc_mem_port2_arbiter.sv
// proc_mem_port2_arbiter
//   Round-robin arbiter sharing the 16-bit second port of a node's dual-port
//   processing memory between NUM_REQ Avalon-MM requesters. It issues at most
//   one access per cycle through a combinational grant, and returns
//   single-cycle-latency read data to the requester that issued the read.
//   A requester may lock the port for read-modify-write sequences. The lock
//   is force-released after LOCK_MAX cycles.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   reset_req            inhibits all grants while high
//   req_*                per-requester Avalon-MM slave side (slice i = requester i)
//   req_waitrequest      low = access accepted this cycle
//   req_readdatavalid    one-hot read response, one cycle after issue
//   req_readdata         shared read data (pass-through of mem_readdata)
//   mem_*                memory port-2 pins (address/chipselect/write/data/be/clken)
//   lock_timeout         sticky flag: a lock was force-released
module proc_mem_port2_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      reset_req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic [BE_W-1:0]           mem_byteenable,
    output logic                      mem_clken,
    input  logic [DATA_W-1:0]         mem_readdata,
    output logic                      lock_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {
        LK_FREE,
        LK_HELD
    } lock_state_t;

    lock_state_t          r_state, w_state_nxt;
    logic [IW-1:0]        r_owner, w_owner_nxt;
    logic [IW-1:0]        r_ptr, w_ptr_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_rdv, w_rdv_nxt;
    logic [NUM_REQ-1:0]   r_nolock, w_nolock_nxt;
    logic                 r_timeout, w_timeout;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [BE_W-1:0]      r_be;

    logic                 w_en;
    logic [NUM_REQ-1:0]   w_pend;
    logic                 w_gvalid;
    logic [IW-1:0]        w_gidx;
    logic [IW-1:0]        w_cand;
    logic [NUM_REQ-1:0]   w_gnt;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata_arr [NUM_REQ];
    logic [BE_W-1:0]      w_be_arr    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_writedata[gi*DATA_W +: DATA_W];
        assign w_be_arr[gi]    = req_byteenable[gi*BE_W +: BE_W];
    end

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] v);
        if (v == IW'(NUM_REQ - 1)) return '0;
        return v + IW'(1);
    endfunction

    // reset_n gates the combinational grant so outputs drop immediately on reset
    assign w_en   = reset_n & ~reset_req;
    assign w_pend = req_read | req_write;

    always_comb begin
        w_gvalid = 1'b0;
        w_gidx   = '0;
        w_cand   = '0;
        if (w_en) begin
            if (r_state == LK_HELD) begin
                w_gvalid = w_pend[r_owner];
                w_gidx   = r_owner;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    w_cand = IW'((int'(r_ptr) + k) % NUM_REQ);
                    if (!w_gvalid && w_pend[w_cand]) begin
                        w_gvalid = 1'b1;
                        w_gidx   = w_cand;
                    end
                end
            end
        end
    end

    assign w_gnt           = w_gvalid ? (NUM_REQ'(1) << w_gidx) : '0;
    assign req_waitrequest = ~w_gnt;
    assign mem_chipselect  = w_gvalid;
    assign mem_write       = w_gvalid & req_write[w_gidx];
    assign mem_clken       = 1'b1;
    assign req_readdata    = mem_readdata;
    assign req_readdatavalid = r_rdv;
    assign lock_timeout    = r_timeout;

    always_comb begin
        mem_address    = r_addr;
        mem_writedata  = r_wdata;
        mem_byteenable = r_be;
        if (w_gvalid) begin
            mem_address    = w_addr_arr[w_gidx];
            mem_writedata  = w_wdata_arr[w_gidx];
            mem_byteenable = w_be_arr[w_gidx];
        end
    end

    // Lock FSM and pointer next-state
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_timeout   = 1'b0;
        case (r_state)
            LK_HELD: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (!req_lock[r_owner]) begin
                    // voluntary release wins over a coincident timeout
                    w_state_nxt = LK_FREE;
                end else if (r_cnt == CW'(LOCK_MAX - 1)) begin
                    w_state_nxt = LK_FREE;
                    w_timeout   = 1'b1;
                    w_ptr_nxt   = f_inc(r_owner);
                end
            end
            default: begin
                if (w_gvalid) begin
                    w_ptr_nxt = f_inc(w_gidx);
                    if (req_lock[w_gidx] && !r_nolock[w_gidx]) begin
                        w_state_nxt = LK_HELD;
                        w_owner_nxt = w_gidx;
                        w_cnt_nxt   = '0;
                    end
                end
            end
        endcase
    end

    // A force-released owner may not re-lock until it drops req_lock once
    assign w_nolock_nxt = (r_nolock & req_lock) |
                          (w_timeout ? (NUM_REQ'(1) << r_owner) : '0);
    assign w_rdv_nxt    = (w_gvalid && !req_write[w_gidx]) ? w_gnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= LK_FREE;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_rdv     <= '0;
            r_nolock  <= '0;
            r_timeout <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rdv    <= w_rdv_nxt;
            r_nolock <= w_nolock_nxt;
            if (w_timeout) r_timeout <= 1'b1;
            if (w_gvalid) begin
                r_addr  <= w_addr_arr[w_gidx];
                r_wdata <= w_wdata_arr[w_gidx];
                r_be    <= w_be_arr[w_gidx];
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_port2_arbiter.sv
// tb_proc_mem_port2_arbiter
//   Bench for proc_mem_port2_arbiter: directed scenarios with literal
//   expectations plus randomized traffic, all checked every cycle against a
//   behavioural model of the arbitration, lock and read-response rules.
module tb_proc_mem_port2_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int LM = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              reset_req = 1'b0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*DW-1:0]   req_writedata = '0;
    logic [N*BW-1:0]   req_byteenable = '0;
    logic [N-1:0]      req_lock = '0;
    logic [N-1:0]      req_waitrequest;
    logic [N-1:0]      req_readdatavalid;
    logic [DW-1:0]     req_readdata;
    logic [AW-1:0]     mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic [BW-1:0]     mem_byteenable;
    logic              mem_clken;
    logic [DW-1:0]     mem_readdata;
    logic              lock_timeout;

    int checks = 0;
    int errors = 0;

    proc_mem_port2_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .BE_W    (BW),
        .LOCK_MAX(LM)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .reset_req        (reset_req),
        .req_address      (req_address),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_writedata    (req_writedata),
        .req_byteenable   (req_byteenable),
        .req_lock         (req_lock),
        .req_waitrequest  (req_waitrequest),
        .req_readdatavalid(req_readdatavalid),
        .req_readdata     (req_readdata),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_byteenable   (mem_byteenable),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .lock_timeout     (lock_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        case (a)
            'h010:   return 16'hA5A5;
            'h020:   return 16'h5A5A;
            'h100:   return 16'h1234;
            default: return DW'(a * 7 + 3);
        endcase
    endfunction

    // Memory port 2: registered address, unregistered data out
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] mem_aq = '0;
    bit            mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= init_val(a);
            mem_init <= 1'b1;
        end else if (mem_chipselect) begin
            mem_aq <= mem_address;
            if (mem_write) begin
                if (mem_byteenable[0]) mem[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) mem[mem_address][15:8] <= mem_writedata[15:8];
            end
        end
    end
    assign mem_readdata = mem[mem_aq];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be, input bit lk);
        req_read[i]                = rd;
        req_write[i]               = wr;
        req_address[i*AW +: AW]    = a;
        req_writedata[i*DW +: DW]  = d;
        req_byteenable[i*BW +: BW] = be;
        req_lock[i]                = lk;
    endtask

    task automatic idle_all();
        req_read = '0; req_write = '0; req_lock = '0;
        req_address = '0; req_writedata = '0; req_byteenable = '0;
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr, m_owner, m_age, m_rdv;
    bit            m_to, m_have_last;
    bit            m_nolock [N];
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_age = 0; m_rdv = -1;
        m_to = 1'b0; m_have_last = 1'b0;
        for (int i = 0; i < N; i++) m_nolock[i] = 1'b0;
    endtask

    task automatic step();
        int            g;
        logic [N-1:0]  pend;
        logic [N-1:0]  exp_wait;
        logic [N-1:0]  exp_rdv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        bit            wr;
        if (!reset_n) begin
            chk("rst_waitrequest", req_waitrequest, 4'hF);
            chk("rst_readdatavalid", req_readdatavalid, 0);
            chk("rst_chipselect", mem_chipselect, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_lock_timeout", lock_timeout, 0);
            model_reset();
            return;
        end
        pend = req_read | req_write;
        exp_rdv = '0;
        if (m_rdv >= 0) exp_rdv[m_rdv] = 1'b1;
        chk("readdatavalid", req_readdatavalid, exp_rdv);
        if (m_rdv >= 0) chk("readdata", req_readdata, m_rdata);
        chk("lock_timeout", lock_timeout, m_to);
        g = -1;
        if (!reset_req) begin
            if (m_owner >= 0) begin
                if (pend[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_wait = '1;
        if (g >= 0) exp_wait[g] = 1'b0;
        chk("waitrequest", req_waitrequest, exp_wait);
        chk("chipselect", mem_chipselect, g >= 0);
        wr = (g >= 0) && req_write[g];
        chk("mem_write", mem_write, wr);
        if (g >= 0) begin
            a  = req_address[g*AW +: AW];
            d  = req_writedata[g*DW +: DW];
            be = req_byteenable[g*BW +: BW];
            chk("mem_address", mem_address, a);
            chk("mem_writedata", mem_writedata, d);
            chk("mem_byteenable", mem_byteenable, be);
            m_last_addr = a;
            m_have_last = 1'b1;
            if (wr) begin
                if (be[0]) ref_mem[a][7:0]  = d[7:0];
                if (be[1]) ref_mem[a][15:8] = d[15:8];
                m_rdv = -1;
            end else begin
                m_rdv   = g;
                m_rdata = ref_mem[a];
            end
        end else begin
            if (m_have_last) chk("mem_address_hold", mem_address, m_last_addr);
            m_rdv = -1;
        end
        if (m_owner >= 0) begin
            m_age++;
            if (!req_lock[m_owner]) begin
                m_owner = -1;
            end else if (m_age == LM) begin
                m_ptr = (m_owner + 1) % N;
                m_nolock[m_owner] = 1'b1;
                m_to = 1'b1;
                m_owner = -1;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (req_lock[g] && !m_nolock[g]) begin
                m_owner = g;
                m_age = 0;
            end
        end
        for (int i = 0; i < N; i++) if (!req_lock[i]) m_nolock[i] = 1'b0;
    endtask

    // Compare process: one model step per cycle, away from the active edge
    initial begin
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(a);
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            step();
        end
    end

    // ---------------- stimulus ----------------
    logic [BW-1:0] be_tab [N];
    logic [N-1:0]  wexp;
    bit            lk_prev [N];

    initial begin
        idle_all();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0, 2'b11, 1'b0);
        #3;
        chk("reset_no_grant", req_waitrequest, 4'hF);
        chk("reset_no_cs", mem_chipselect, 0);
        @(negedge clk);
        idle_all();
        reset_n = 1'b1;

        // two simultaneous reads, pointer at 0
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 14'h0010, '0, 2'b11, 1'b0);
        set_req(2, 1'b1, 1'b0, 14'h0020, '0, 2'b11, 1'b0);
        #3;
        chk("t1_wait_T", req_waitrequest, 4'b1110);
        chk("t1_addr_T", mem_address, 14'h0010);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("t1_wait_T1", req_waitrequest, 4'b1011);
        chk("t1_rdv_T1", req_readdatavalid, 4'b0001);
        chk("t1_data_T1", req_readdata, 16'hA5A5);
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("t1_rdv_T2", req_readdatavalid, 4'b0100);
        chk("t1_data_T2", req_readdata, 16'h5A5A);

        // all four writing continuously; pointer is 3 after the reads above
        be_tab[0] = 2'b01; be_tab[1] = 2'b10; be_tab[2] = 2'b11; be_tab[3] = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                set_req(i, 1'b0, 1'b1, AW'(14'h40 + i), DW'($urandom), be_tab[i], 1'b0);
            #3;
            wexp = '1;
            wexp[(3 + c) % N] = 1'b0;
            chk("t2_rotation", req_waitrequest, wexp);
            chk("t2_be", mem_byteenable, be_tab[(3 + c) % N]);
        end
        @(negedge clk);
        idle_all();

        // locked read-modify-write by requester 1 with requester 3 contending
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 14'h0100, '0, 2'b11, 1'b1);
        #3;
        chk("t3_lock_read", req_waitrequest, 4'b1101);
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 14'h0100, 16'hBEEF, 2'b11, 1'b0);
        set_req(3, 1'b1, 1'b0, 14'h0100, '0, 2'b11, 1'b0);
        #3;
        chk("t3_owner_write", req_waitrequest, 4'b1101);
        chk("t3_write_issued", mem_write, 1);
        chk("t3_rdv_owner", req_readdatavalid, 4'b0010);
        chk("t3_read_old", req_readdata, 16'h1234);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("t3_other_after", req_waitrequest, 4'b0111);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("t3_rdv_other", req_readdatavalid, 4'b1000);
        chk("t3_read_new", req_readdata, 16'hBEEF);

        // lock held forever by requester 2 -> timeout
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 14'h0200, '0, 2'b11, 1'b1);
        #3;
        chk("t4_acquire", req_waitrequest, 4'b1011);
        for (int c = 1; c <= LM; c++) begin
            @(negedge clk);
            set_req(3, 1'b1, 1'b0, 14'h0300, '0, 2'b11, 1'b0);
            #3;
            chk("t4_locked", req_waitrequest, 4'b1011);
            if (c == LM) chk("t4_no_timeout_yet", lock_timeout, 0);
        end
        @(negedge clk);
        #3;
        chk("t4_other_granted", req_waitrequest, 4'b0111);
        chk("t4_timeout_flag", lock_timeout, 1);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("t4_owner_unlocked_grant", req_waitrequest, 4'b1011);
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 14'h0300, '0, 2'b11, 1'b0);
        #3;
        chk("t4_no_relock", req_waitrequest, 4'b0111);
        @(negedge clk);
        idle_all();

        // reset_req window with everyone pending
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(14'h10 + i), '0, 2'b11, 1'b0);
        #3;
        chk("t5_before", req_waitrequest, 4'b1110);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            reset_req = 1'b1;
            #3;
            chk("t5_inhibit", req_waitrequest, 4'hF);
            if (c == 1) chk("t5_rdv_survives", req_readdatavalid, 4'b0001);
        end
        @(negedge clk);
        reset_req = 1'b0;
        #3;
        chk("t5_resume", req_waitrequest, 4'b1101);
        @(negedge clk);
        idle_all();

        // randomized traffic
        for (int i = 0; i < N; i++) lk_prev[i] = 1'b0;
        repeat (1500) begin
            @(negedge clk);
            reset_req = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                int  rw;
                bit  lk;
                rw = $urandom_range(0, 5);
                lk = lk_prev[i] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
                lk_prev[i] = lk;
                set_req(i, rw inside {2, 3, 5}, rw inside {4, 5},
                        AW'($urandom_range(0, 63)), DW'($urandom),
                        BW'($urandom_range(0, 3)), lk);
            end
        end
        @(negedge clk);
        reset_req = 1'b0;
        idle_all();

        // asynchronous reset in the middle of a read burst
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(14'h20 + i), '0, 2'b11, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_wait_reset", req_waitrequest, 4'hF);
        chk("t7_rdv_dropped", req_readdatavalid, 0);
        chk("t7_cs_reset", mem_chipselect, 0);
        chk("t7_write_reset", mem_write, 0);
        chk("t7_timeout_cleared", lock_timeout, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        chk("t7_ptr_zero", req_waitrequest, 4'b1110);
        chk("t7_no_stale_rdv", req_readdatavalid, 0);
        @(negedge clk);
        idle_all();
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
